div_rem_sequencer: RTL and testbench

- Multi-cycle sequencer for the signed DIV and REM operations in the EX stage of the 32-bit RISC-V pipeline.
- Accepts an operation when the ALU control code selects DIV (4'b0110) or REM (4'b1010).
- Runs a radix-2 restoring divide on operand magnitudes and holds the pipeline via `stall` until the result is ready.
- All other ALU codes pass through untouched; the single-cycle ALU handles them.

---
 rtl/div_rem_sequencer_if.sv | 26 ++
 rtl/div_rem_sequencer.sv | 139 +++++++++++++
 tb/tb_div_rem_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_rem_sequencer_if.sv
// EX-stage handshake between the pipeline and the DIV/REM sequencer.
interface div_rem_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             flush;
   logic [3:0]       ALUControl;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Result;

   // Pipeline side: issues operations and consumes the result.
   modport master (
      output start, flush, ALUControl, SrcA, SrcB,
      input  stall, busy, done, Result
   );

   // Sequencer side.
   modport slave (
      input  start, flush, ALUControl, SrcA, SrcB,
      output stall, busy, done, Result
   );
endinterface

// File: rtl/div_rem_sequencer.sv
// Multi-cycle signed DIV/REM sequencer for the EX stage. Radix-2 restoring
// divide on operand magnitudes, one quotient bit per cycle, with RISC-V M
// results for divide-by-zero and signed overflow.
module div_rem_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input logic                clk,
   input logic                rst,
   div_rem_sequencer_if.slave bus
);

   localparam logic [3:0] ALU_DIV = 4'b0110;
   localparam logic [3:0] ALU_REM = 4'b1010;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             op_rem;
   logic             sign_q;
   logic             sign_r;
   logic [WIDTH-1:0] dvd;   // dividend shifts out the top, quotient fills the bottom
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;

   logic             is_div;
   logic             is_rem;
   logic             accept;
   logic             div_zero;
   logic             ovf;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] rem_sh;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] res_fix;

   // Operation decode, operand magnitudes and one restoring step.
   always_comb begin
      // NOTE: every signal of this block is given a value up front so no latch can be inferred.
      is_div   = (bus.ALUControl == ALU_DIV);
      is_rem   = (bus.ALUControl == ALU_REM);
      accept   = bus.start & (is_div | is_rem) & ~bus.flush;
      div_zero = (bus.SrcB == '0);
      ovf      = (bus.SrcA == {1'b1, {(WIDTH-1){1'b0}}}) & (bus.SrcB == '1);
      abs_a    = bus.SrcA[WIDTH-1] ? -bus.SrcA : bus.SrcA;
      abs_b    = bus.SrcB[WIDTH-1] ? -bus.SrcB : bus.SrcB;
      // rem < dvs <= 2^(WIDTH-1), so dropping rem's top bit on the shift loses nothing.
      rem_sh   = {rem[WIDTH-2:0], dvd[WIDTH-1]};
      rem_nxt  = rem_sh;
      q_nxt    = {dvd[WIDTH-2:0], 1'b0};
      if (rem_sh >= dvs) begin
         rem_nxt  = rem_sh - dvs;
         q_nxt[0] = 1'b1;
      end
      if (op_rem) res_fix = sign_r ? -rem_nxt : rem_nxt;
      else        res_fix = sign_q ? -q_nxt   : q_nxt;
   end

   // Hold the pipeline while an accepted op is being issued or iterated.
   assign bus.stall = ~rst & ((state == IDLE & accept) | (state == CALC));

   // Sequencer FSM with registered busy/done/Result.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: datapath registers are reset as well, so Result reads 0 after reset rather than X.
         state      <= IDLE;
         cnt        <= '0;
         op_rem     <= 1'b0;
         sign_q     <= 1'b0;
         sign_r     <= 1'b0;
         dvd        <= '0;
         dvs        <= '0;
         rem        <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.Result <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (accept) begin
                  op_rem <= is_rem;
                  sign_q <= bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1];
                  sign_r <= bus.SrcA[WIDTH-1];
                  dvd    <= abs_a;
                  dvs    <= abs_b;
                  rem    <= '0;
                  cnt    <= '0;
                  if (div_zero) begin
                     bus.Result <= is_rem ? bus.SrcA : '1;
                     bus.done   <= 1'b1;
                     state      <= DONE;
                  end else if (ovf) begin
                     bus.Result <= is_rem ? '0 : bus.SrcA;
                     bus.done   <= 1'b1;
                     state      <= DONE;
                  end else begin
                     bus.busy <= 1'b1;
                     state    <= CALC;
                  end
               end
            end
            CALC: begin
               if (bus.flush) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  rem <= rem_nxt;
                  dvd <= q_nxt;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(WIDTH-1)) begin
                     bus.Result <= res_fix;
                     bus.busy   <= 1'b0;
                     bus.done   <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_rem_sequencer.sv
// Self-checking bench for div_rem_sequencer: scoreboard of expected results
// pushed on issue and popped on the done pulse.
module tb_div_rem_sequencer;

   localparam logic [3:0] ALU_DIV = 4'b0110;
   localparam logic [3:0] ALU_REM = 4'b1010;
   localparam logic [3:0] ALU_ADD = 4'b0000;

   typedef struct {
      logic [31:0] result;
      int          lat;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   div_rem_sequencer_if #(.WIDTH(32)) dif ();

   div_rem_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   always #5 clk = ~clk;

   // Reference result following RISC-V M semantics.
   function automatic logic [31:0] model(input bit op_rem, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op_rem ? a : 32'hFFFF_FFFF;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op_rem ? 32'd0 : 32'h8000_0000;
      if (op_rem) return sa % sb;
      return sa / sb;
   endfunction

   // Issue one op with start held until done, check latency, stall, busy and Result.
   task automatic run_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expected, input string name);
      exp_t e;
      int   stall_cycles = 0;
      int   busy_cycles = 0;
      int   done_cyc = -1;
      bit   special;
      special  = (b == 32'd0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      e.result = expected;
      e.lat    = special ? 1 : 33;
      e.name   = name;
      @(negedge clk);
      dif.start      = 1'b1;
      dif.flush      = 1'b0;
      dif.ALUControl = ctl;
      dif.SrcA       = a;
      dif.SrcB       = b;
      sb_q.push_back(e);
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (dif.done) begin
            done_cyc = c;
            break;
         end
         if (dif.stall) stall_cycles++;
         if (dif.busy) busy_cycles++;
      end
      e = sb_q.pop_front();
      checks++;
      if (done_cyc !== e.lat) begin
         errors++;
         $display("FAIL %s latency: got done at cycle %0d, expected %0d", e.name, done_cyc, e.lat);
      end
      checks++;
      if (stall_cycles !== e.lat) begin
         errors++;
         $display("FAIL %s stall cycles: got %0d, expected %0d", e.name, stall_cycles, e.lat);
      end
      checks++;
      if (busy_cycles !== e.lat - 1) begin
         errors++;
         $display("FAIL %s busy cycles: got %0d, expected %0d", e.name, busy_cycles, e.lat - 1);
      end
      if (done_cyc >= 0) begin
         checks++;
         if (dif.stall !== 1'b0) begin
            errors++;
            $display("FAIL %s stall in done cycle: got %b, expected 0", e.name, dif.stall);
         end
         checks++;
         if (dif.Result !== e.result) begin
            errors++;
            $display("FAIL %s Result: got %h, expected %h", e.name, dif.Result, e.result);
         end
      end
      dif.start = 1'b0;
   endtask

   task automatic test_reset();
      dif.start      = 1'b1;
      dif.flush      = 1'b0;
      dif.ALUControl = ALU_DIV;
      dif.SrcA       = 32'd100;
      dif.SrcB       = 32'd7;
      #2;
      checks++;
      if ({dif.stall, dif.busy, dif.done} !== 3'b000) begin
         errors++;
         $display("FAIL reset flags: got stall/busy/done=%b, expected 000", {dif.stall, dif.busy, dif.done});
      end
      checks++;
      if (dif.Result !== 32'd0) begin
         errors++;
         $display("FAIL reset Result: got %h, expected 00000000", dif.Result);
      end
      @(negedge clk);
      dif.start = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic test_normal();
      run_op(ALU_DIV, 32'd100, 32'd7, 32'd14, "div_100_7");
      run_op(ALU_REM, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, "rem_m7_3");
      run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFE, "div_m7_3");
      run_op(ALU_REM, 32'd7, 32'hFFFF_FFFD, 32'd1, "rem_7_m3");
      run_op(ALU_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, "div_min_2");
   endtask

   task automatic test_special();
      run_op(ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
      run_op(ALU_REM, 32'd5, 32'd0, 32'd5, "rem_by_zero");
      run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
      run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_overflow");
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      bit          op;
      for (int i = 0; i < 6; i++) begin
         a  = $urandom;
         b  = $urandom_range(1, 5000);
         if ($urandom_range(0, 1) == 1) b = -b;
         op = ($urandom_range(0, 1) == 1);
         run_op(op ? ALU_REM : ALU_DIV, a, b, model(op, a, b), op ? "rand_rem" : "rand_div");
      end
   endtask

   task automatic test_back_to_back();
      run_op(ALU_DIV, 32'd1000, 32'd10, 32'd100, "b2b_first");
      run_op(ALU_DIV, 32'd81, 32'd9, 32'd9, "b2b_second");
   endtask

   task automatic test_passthrough();
      int bad = 0;
      @(negedge clk);
      dif.start      = 1'b1;
      dif.ALUControl = ALU_ADD;
      dif.SrcA       = 32'd12;
      dif.SrcB       = 32'd4;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (dif.stall || dif.busy || dif.done) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL passthrough: got %0d cycles with stall/busy/done high, expected 0", bad);
      end
      dif.start = 1'b0;
   endtask

   task automatic test_flush();
      int pulses = 0;
      // flush in IDLE blocks acceptance
      @(negedge clk);
      dif.start      = 1'b1;
      dif.flush      = 1'b1;
      dif.ALUControl = ALU_DIV;
      dif.SrcA       = 32'd50;
      dif.SrcB       = 32'd5;
      #1;
      checks++;
      if (dif.stall !== 1'b0) begin
         errors++;
         $display("FAIL idle_flush stall: got %b, expected 0", dif.stall);
      end
      @(negedge clk);
      #1;
      checks++;
      if (dif.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_flush busy: got %b, expected 0", dif.busy);
      end
      // flush at CALC cycle 10
      dif.flush = 1'b0;
      dif.SrcA  = 32'd1000;
      dif.SrcB  = 32'd3;
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if (dif.busy !== 1'b1) begin
         errors++;
         $display("FAIL calc_flush pre busy: got %b, expected 1", dif.busy);
      end
      dif.flush = 1'b1;
      dif.start = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({dif.busy, dif.stall, dif.done} !== 3'b000) begin
         errors++;
         $display("FAIL calc_flush exit: got busy/stall/done=%b, expected 000", {dif.busy, dif.stall, dif.done});
      end
      dif.flush = 1'b0;
      for (int c = 0; c < 36; c++) begin
         @(negedge clk);
         if (dif.done) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL calc_flush done pulses: got %0d, expected 0", pulses);
      end
      run_op(ALU_DIV, 32'd9, 32'd3, 32'd3, "after_flush_div_9_3");
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      dif.start      = 1'b1;
      dif.ALUControl = ALU_DIV;
      dif.SrcA       = 32'd1000;
      dif.SrcB       = 32'd7;
      repeat (5) @(negedge clk);
      #1;
      dif.start = 1'b0;
      checks++;
      if (dif.busy !== 1'b1) begin
         errors++;
         $display("FAIL async_rst pre busy: got %b, expected 1", dif.busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({dif.busy, dif.done, dif.stall} !== 3'b000) begin
         errors++;
         $display("FAIL async_rst flags: got busy/done/stall=%b, expected 000", {dif.busy, dif.done, dif.stall});
      end
      checks++;
      if (dif.Result !== 32'd0) begin
         errors++;
         $display("FAIL async_rst Result: got %h, expected 00000000", dif.Result);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (dif.busy !== 1'b0) begin
         errors++;
         $display("FAIL async_rst post busy: got %b, expected 0", dif.busy);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_special();
      test_back_to_back();
      test_passthrough();
      test_random();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
